// File: rtl/balanca_pkg.sv
// Shared types, widths and error codes for the scale pricing controller.
package balanca_pkg;

    localparam int W_WEIGHT = 12;
    localparam int W_PROD   = 24;
    localparam int W_PRICE  = 19;
    localparam int W_TOTAL  = 24;
    localparam int W_COUNT  = 8;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_UNDER   = 2'd1;
    localparam logic [1:0] ERR_EMPTY   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {IDLE, SETTLE, MULT, DIV, ACCUM, DONE} state_t;

    typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV} md_phase_t;

    // Running total plus one item price, clamped at the all-ones total.
    function automatic logic [W_TOTAL-1:0] sat_add_total(input logic [W_TOTAL-1:0] total,
                                                         input logic [W_PRICE-1:0] price);
        logic [W_TOTAL:0] sum;
        sum = {1'b0, total} + {{(W_TOTAL+1-W_PRICE){1'b0}}, price};
        return sum[W_TOTAL] ? {W_TOTAL{1'b1}} : sum[W_TOTAL-1:0];
    endfunction

endpackage

// File: rtl/balanca_ctrl_muldiv.sv
// Serial shift-add multiplier followed by a rounded restoring divide.
// Handshake: start is honoured only while ready is high; operands a/b are
// captured on that edge. mul_done pulses on the last multiply cycle (product
// is valid the following cycle), done pulses on the last divide cycle
// (quotient is valid the following cycle). Results hold until the next run.
module serial_muldiv
    import balanca_pkg::*;
#(
    parameter int DIVISOR = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [W_WEIGHT-1:0] a,
    input  logic [W_WEIGHT-1:0] b,
    output logic                ready,
    output logic                mul_done,
    output logic                done,
    output logic [W_PROD-1:0]   product,
    output logic [W_PRICE-1:0]  quotient,
    output md_phase_t           dbg_phase
);

    localparam int CNT_W = 5;
    localparam int REM_W = $clog2(DIVISOR);
    localparam logic [CNT_W-1:0]  MUL_LAST = CNT_W'(W_WEIGHT - 1);
    localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(W_PROD - 1);
    localparam logic [W_PROD-1:0] HALF     = W_PROD'(DIVISOR / 2);
    localparam logic [REM_W:0]    DIV_K    = (REM_W + 1)'(DIVISOR);

    md_phase_t          phase, phase_nx;
    logic [CNT_W-1:0]   cnt;
    logic [W_PROD-1:0]  mcand, acc, acc_nx, dvd;
    logic [W_WEIGHT-1:0] mplier;
    logic [REM_W-1:0]   rem, rem_nx;
    logic [REM_W:0]     rem_sh;
    logic               rem_ge;

    assign ready     = (phase == MD_IDLE);
    assign dbg_phase = phase;
    assign acc_nx    = mplier[0] ? acc + mcand : acc;
    assign rem_sh    = {rem, dvd[W_PROD-1]};
    assign rem_ge    = (rem_sh >= DIV_K);
    assign rem_nx    = rem_ge ? REM_W'(rem_sh - DIV_K) : rem_sh[REM_W-1:0];

    // Phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase <= MD_IDLE;
        else     phase <= phase_nx;
    end

    // Phase sequencing and completion strobes.
    always_comb begin
        phase_nx = phase;
        mul_done = 1'b0;
        done     = 1'b0;
        case (phase)
            MD_IDLE: if (start) phase_nx = MD_MUL;
            MD_MUL: if (cnt == MUL_LAST) begin
                mul_done = 1'b1;
                phase_nx = MD_DIV;
            end
            MD_DIV: if (cnt == DIV_LAST) begin
                done     = 1'b1;
                phase_nx = MD_IDLE;
            end
            default: phase_nx = MD_IDLE;
        endcase
    end

    // Datapath: one multiplier bit (LSB first) or one quotient bit per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            dvd      <= '0;
            rem      <= '0;
            product  <= '0;
            quotient <= '0;
        end else begin
            case (phase)
                MD_IDLE: if (start) begin
                    mcand  <= W_PROD'(a);
                    mplier <= b;
                    acc    <= '0;
                    cnt    <= '0;
                end
                MD_MUL: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == MUL_LAST) begin
                        // Half the divisor is added so truncating division rounds half up.
                        product <= acc_nx;
                        dvd     <= acc_nx + HALF;
                        rem     <= '0;
                        cnt     <= '0;
                    end
                end
                MD_DIV: begin
                    rem <= rem_nx;
                    dvd <= {dvd[W_PROD-2:0], rem_ge};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == DIV_LAST) begin
                        quotient <= {dvd[W_PRICE-2:0], rem_ge};
                        cnt      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/balanca_ctrl.sv
// Scale transaction controller: tare, stability wait, pricing and sale totals.
module balanca_ctrl
    import balanca_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int DIVISOR        = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W_WEIGHT-1:0] rawWeight,
    input  logic [W_WEIGHT-1:0] centimos,
    input  logic                tareBtn,
    input  logic                calcBtn,
    input  logic                clearBtn,
    output logic                busy,
    output logic                done,
    output logic [W_WEIGHT-1:0] netWeight,
    output logic [25:0]         precotara,
    output logic [W_PRICE-1:0]  precof,
    output logic [W_TOTAL-1:0]  totalCents,
    output logic [W_COUNT-1:0]  itemCount,
    output logic [1:0]          errCode,
    output state_t              dbg_state,
    output md_phase_t           dbg_phase
);

    localparam int STAB_W = $clog2(STABLE_CYCLES);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t              state, state_nx;
    logic [W_WEIGHT-1:0] tare_reg, prev_sample, net_diff;
    logic [STAB_W-1:0]   stab_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                match, stable_hit, under;
    logic                do_clear, do_tare, do_calc, err_load, net_load, do_accum;
    logic [1:0]          err_nx;
    logic                md_start, md_ready, md_mul_done, md_done;
    logic [W_PROD-1:0]   md_product;

    assign match      = (rawWeight == prev_sample);
    assign stable_hit = match && (stab_cnt == STAB_LAST);
    assign under      = (rawWeight < tare_reg);
    assign net_diff   = rawWeight - tare_reg;

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign dbg_state  = state;
    assign precotara  = {2'b00, md_product};

    serial_muldiv #(.DIVISOR(DIVISOR)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start),
        .a         (net_diff),
        .b         (centimos),
        .ready     (md_ready),
        .mul_done  (md_mul_done),
        .done      (md_done),
        .product   (md_product),
        .quotient  (precof),
        .dbg_phase (dbg_phase)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and datapath strobes; buttons only act in IDLE, clear > tare > calc.
    always_comb begin
        state_nx = state;
        do_clear = 1'b0;
        do_tare  = 1'b0;
        do_calc  = 1'b0;
        err_load = 1'b0;
        err_nx   = ERR_OK;
        net_load = 1'b0;
        md_start = 1'b0;
        do_accum = 1'b0;
        case (state)
            IDLE: begin
                if (clearBtn)     do_clear = 1'b1;
                else if (tareBtn) do_tare  = 1'b1;
                else if (calcBtn) begin
                    do_calc  = 1'b1;
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (stable_hit) begin
                    if (under) begin
                        err_load = 1'b1;
                        err_nx   = ERR_UNDER;
                        state_nx = IDLE;
                    end else if (net_diff == '0) begin
                        err_load = 1'b1;
                        err_nx   = ERR_EMPTY;
                        state_nx = IDLE;
                    end else if (md_ready) begin
                        md_start = 1'b1;
                        net_load = 1'b1;
                        state_nx = MULT;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    err_load = 1'b1;
                    err_nx   = ERR_TIMEOUT;
                    state_nx = IDLE;
                end
            end
            MULT:  if (md_mul_done) state_nx = DIV;
            DIV:   if (md_done)     state_nx = ACCUM;
            ACCUM: begin
                do_accum = 1'b1;
                state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Tare, stability/timeout counters, error code and sale accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tare_reg    <= '0;
            prev_sample <= '0;
            stab_cnt    <= '0;
            tmo_cnt     <= '0;
            netWeight   <= '0;
            totalCents  <= '0;
            itemCount   <= '0;
            errCode     <= ERR_OK;
        end else begin
            prev_sample <= rawWeight;
            if (do_clear) begin
                totalCents <= '0;
                itemCount  <= '0;
                errCode    <= ERR_OK;
            end
            if (do_tare) tare_reg <= rawWeight;
            if (do_calc) begin
                errCode  <= ERR_OK;
                stab_cnt <= '0;
                tmo_cnt  <= '0;
            end
            if (state == SETTLE) begin
                stab_cnt <= match ? stab_cnt + STAB_W'(1) : '0;
                tmo_cnt  <= tmo_cnt + TMO_W'(1);
            end
            if (err_load) errCode   <= err_nx;
            if (net_load) netWeight <= net_diff;
            if (do_accum) begin
                totalCents <= sat_add_total(totalCents, precof);
                itemCount  <= (itemCount == '1) ? itemCount : itemCount + W_COUNT'(1);
            end
        end
    end

endmodule

// File: tb/tb_balanca_ctrl.sv
// Directed bench for balanca_ctrl with an expected-result queue checked on each completion.
module tb_balanca_ctrl;
  import balanca_pkg::*;

  localparam int EXP_W = 92;

  logic        clk;
  logic        rst;
  logic [11:0] rawWeight, centimos;
  logic        tareBtn, calcBtn, clearBtn;
  logic        busy, done;
  logic [11:0] netWeight;
  logic [25:0] precotara;
  logic [18:0] precof;
  logic [23:0] totalCents;
  logic [7:0]  itemCount;
  logic [1:0]  errCode;
  state_t      dbg_state;
  md_phase_t   dbg_phase;

  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  balanca_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rawWeight  (rawWeight),
    .centimos   (centimos),
    .tareBtn    (tareBtn),
    .calcBtn    (calcBtn),
    .clearBtn   (clearBtn),
    .busy       (busy),
    .done       (done),
    .netWeight  (netWeight),
    .precotara  (precotara),
    .precof     (precof),
    .totalCents (totalCents),
    .itemCount  (itemCount),
    .errCode    (errCode),
    .dbg_state  (dbg_state),
    .dbg_phase  (dbg_phase)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic logic [EXP_W-1:0] pack(input logic [1:0] err, input logic [11:0] net,
                                             input logic [25:0] prod, input logic [18:0] price,
                                             input logic [23:0] total, input logic [7:0] cnt,
                                             input logic dn);
    return {err, net, prod, price, total, cnt, dn};
  endfunction

  // driver: one-cycle button pulse
  task automatic pulse(input logic t, input logic c, input logic cl);
    @(posedge clk); #1;
    tareBtn = t; calcBtn = c; clearBtn = cl;
    @(posedge clk); #1;
    tareBtn = 1'b0; calcBtn = 1'b0; clearBtn = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL %s: no completion within %0d cycles, %0d results pending, expected 0",
               name, budget, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_item(input string name, input logic [11:0] w, input logic [11:0] cents,
                          input logic [EXP_W-1:0] e);
    rawWeight = w;
    centimos  = cents;
    exp_q.push_back(e);
    pulse(1'b0, 1'b1, 1'b0);
    wait_idle(name, 300);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},       32'(busy), 0);
    check({tag, "_done"},       32'(done), 0);
    check({tag, "_netWeight"},  32'(netWeight), 0);
    check({tag, "_precotara"},  32'(precotara), 0);
    check({tag, "_precof"},     32'(precof), 0);
    check({tag, "_totalCents"}, 32'(totalCents), 0);
    check({tag, "_itemCount"},  32'(itemCount), 0);
    check({tag, "_errCode"},    32'(errCode), 0);
    check({tag, "_state"},      32'(dbg_state), 32'(IDLE));
  endtask

  // scoreboard monitor: latency on done, full result compare when busy falls
  initial begin : monitor
    logic prev_busy, prev_done, done_seen;
    state_t prev_st;
    int cyc, mult_cyc;
    logic [EXP_W-1:0] e;
    prev_busy = 1'b0; prev_done = 1'b0; done_seen = 1'b0;
    prev_st = IDLE; cyc = 0; mult_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_busy = 1'b0; prev_done = 1'b0; done_seen = 1'b0; prev_st = IDLE;
      end else begin
        if (dbg_state == MULT && prev_st != MULT) mult_cyc = cyc;
        if (done) begin
          done_seen = 1'b1;
          check("latency_mult_to_done", 32'(cyc - mult_cyc + 1), 38);
        end
        if (prev_done) check("busy_after_done", 32'(busy), 0);
        if (prev_busy && !busy) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_completion: got a completion, expected none");
          end else begin
            e = exp_q.pop_front();
            check("errCode",    32'(errCode),    32'(e[91:90]));
            check("netWeight",  32'(netWeight),  32'(e[89:78]));
            check("precotara",  32'(precotara),  32'(e[77:52]));
            check("precof",     32'(precof),     32'(e[51:33]));
            check("totalCents", 32'(totalCents), 32'(e[32:9]));
            check("itemCount",  32'(itemCount),  32'(e[8:1]));
            check("done_pulse", 32'(done_seen),  32'(e[0]));
          end
          done_seen = 1'b0;
        end
        prev_busy = busy;
        prev_done = done;
        prev_st   = dbg_state;
      end
    end
  end

  // stimulus
  initial begin : stimulus
    int k;
    int unsigned t;
    rst = 1'b1;
    rawWeight = '0; centimos = '0;
    tareBtn = 1'b0; calcBtn = 1'b0; clearBtn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // basic pricing, tare 0
    run_item("basic", 12'd1500, 12'd470,
             pack(2'd0, 12'd1500, 26'd705000, 19'd705, 24'd705, 8'd1, 1'b1));

    // tare at 200, then 1700 gross
    rawWeight = 12'd200;
    pulse(1'b1, 1'b0, 1'b0);
    run_item("tare", 12'd1700, 12'd470,
             pack(2'd0, 12'd1500, 26'd705000, 19'd705, 24'd1410, 8'd2, 1'b1));
    run_item("under_tare", 12'd150, 12'd470,
             pack(2'd1, 12'd1500, 26'd705000, 19'd705, 24'd1410, 8'd2, 1'b0));

    // tare back to 0, empty platter
    rawWeight = 12'd0;
    pulse(1'b1, 1'b0, 1'b0);
    run_item("empty", 12'd0, 12'd470,
             pack(2'd2, 12'd1500, 26'd705000, 19'd705, 24'd1410, 8'd2, 1'b0));

    // rounding
    run_item("round_up", 12'd1500, 12'd1,
             pack(2'd0, 12'd1500, 26'd1500, 19'd2, 24'd1412, 8'd3, 1'b1));
    run_item("round_down", 12'd1499, 12'd1,
             pack(2'd0, 12'd1499, 26'd1499, 19'd1, 24'd1413, 8'd4, 1'b1));
    run_item("max_operands", 12'd4095, 12'd4095,
             pack(2'd0, 12'd4095, 26'd16769025, 19'd16769, 24'd18182, 8'd5, 1'b1));

    // never-stable weight -> timeout, results untouched
    rawWeight = 12'd1000;
    exp_q.push_back(pack(2'd3, 12'd4095, 26'd16769025, 19'd16769, 24'd18182, 8'd5, 1'b0));
    fork
      begin
        for (int i = 0; i < 460; i++) begin
          repeat (10) @(posedge clk);
          #1 rawWeight = rawWeight ^ 12'd1;
        end
      end
      begin
        pulse(1'b0, 1'b1, 1'b0);
        wait_idle("timeout", 5000);
      end
    join

    // clear wins over calc in the same cycle
    pulse(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("prio_busy",       32'(busy), 0);
    check("prio_errCode",    32'(errCode), 0);
    check("prio_totalCents", 32'(totalCents), 0);
    check("prio_itemCount",  32'(itemCount), 0);
    repeat (3) @(negedge clk);
    check("prio_still_idle", 32'(dbg_state), 32'(IDLE));

    // clear wins over tare: tare must stay 0
    rawWeight = 12'd77;
    pulse(1'b1, 1'b0, 1'b1);

    // saturation of total (after 1001 max items) and count (after 255)
    for (int i = 1; i <= 1001; i++) begin
      t = 32'(i) * 32'd16769;
      if (t > 32'd16777215) t = 32'd16777215;
      run_item("saturate", 12'd4095, 12'd4095,
               pack(2'd0, 12'd4095, 26'd16769025, 19'd16769, 24'(t),
                    (i > 255) ? 8'd255 : 8'(i), 1'b1));
    end
    check("sat_total_final", 32'(totalCents), 32'd16777215);
    check("sat_count_final", 32'(itemCount), 32'd255);

    // reset while dividing
    rawWeight = 12'd1500;
    centimos  = 12'd470;
    pulse(1'b0, 1'b1, 1'b0);
    k = 0;
    while (dbg_state != DIV && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reach_div", 32'(dbg_state == DIV), 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("reset_in_div");
    @(negedge clk);
    rst = 1'b0;

    run_item("after_reset", 12'd1500, 12'd470,
             pack(2'd0, 12'd1500, 26'd705000, 19'd705, 24'd705, 8'd1, 1'b1));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
